floo_rob_tagged: RTL and testbench
==================================

Name: floo_rob_tagged

Overview:
Parametrised tagged reorder buffer for FlooNoC chimneys. It releases responses in allocation order even when they return from the network out of order.
- Requests allocate a slot in program order and carry the returned index as their tag.
- Responses are written back by tag in any order.
- The head is drained in order. An optional same-cycle bypass is available, and writes to unallocated or already-filled slots are detected.
- Sits between the chimney's response ejection path and its AXI response output. It is the synthesizable generalisation of the fixed-size buffer exercised by the existing ROB bench.

Parameters:
- DataWidth, 64, width of response payload stored per slot.
- Depth, 64, number of slots. Power of two, >= 2.
- BypassEn, 1'b1, allow a response for the empty head slot to pass to the output in the same cycle.
- IdxWidth, $clog2(Depth), derived slot index width. Do not override.

Ports:
- clk_i, in, 1, clock; all state updates on rising edge.
- rst_i, in, 1, synchronous active-high reset.
- alloc_valid_i, in, 1, request to allocate the next slot.
- alloc_ready_o, out, 1, slot available (buffer not full).
- alloc_idx_o, out, IdxWidth, index of the slot granted on the alloc handshake.
- rsp_valid_i, in, 1, response write strobe.
- rsp_ready_o, out, 1, tied 1; responses are never back-pressured.
- rsp_idx_i, in, IdxWidth, target slot of the response.
- rsp_data_i, in, DataWidth, response payload.
- out_valid_o, out, 1, head response available.
- out_ready_i, in, 1, consumer accepts head.
- out_data_o, out, DataWidth, head payload.
- count_o, out, IdxWidth+1, number of allocated (un-popped) slots.
- err_o, out, 1, one-cycle pulse: previous-cycle response targeted a slot that was not allocated or already filled.

Behaviour:
State:
- wr_ptr and rd_ptr, each IdxWidth+1 bits (MSB is the wrap bit).
- Per-slot alloc and filled bits.
- Data storage (flip-flop array).

Reset (rst_i=1 at clock edge):
- Pointers and all alloc/filled bits cleared.
- err_o=0. Storage contents are don't-care.
- Outputs after reset: alloc_ready_o=1, alloc_idx_o=0, out_valid_o=0, count_o=0, err_o=0.
- Reset mid-operation discards all in-flight slots; no output is produced for them.

Allocation:
- full = (wr_ptr[IdxWidth] != rd_ptr[IdxWidth]) && low bits equal. alloc_ready_o = !full.
- alloc_ready_o does not depend on the same-cycle pop.
- alloc_idx_o = wr_ptr[IdxWidth-1:0], combinational from state.
- On alloc_valid_i && alloc_ready_o: alloc[idx] set, filled[idx] cleared, wr_ptr increments (wraps modulo 2*Depth).

Response write:
- legal = alloc[rsp_idx_i] && !filled[rsp_idx_i], evaluated on pre-edge state.
- Legal write: data stored, filled set at the edge.
- Illegal write: dropped; err_o=1 in the following cycle only. Back-to-back illegal writes give back-to-back pulses.
- A write to the head slot in the same cycle the head pops is illegal only if the head is already filled (double fill).

Output:
- head = rd_ptr[IdxWidth-1:0].
- Normal path: out_valid_o = filled[head]; out_data_o = data[head]. Latency from rsp write to out_valid_o is 1 cycle.
- Bypass (BypassEn=1): when alloc[head] && !filled[head] && rsp_valid_i && rsp_idx_i==head:
  - out_valid_o=1 and out_data_o=rsp_data_i in the same cycle (0-cycle latency).
  - If out_ready_i=1, the slot is freed without being filled.
  - Otherwise the slot is filled normally.
- With BypassEn=0, out_valid_o depends on registered state only.
- Pop on out_valid_o && out_ready_i: alloc[head] and filled[head] cleared, rd_ptr increments.
- out_valid_o must stay high and out_data_o stable until accepted (AXI-style).

Simultaneous events:
- Alloc and pop in the same cycle: count unchanged.
- Alloc into a slot is only possible after that slot was popped in an earlier cycle. The full flag guarantees this.

count_o = wr_ptr - rd_ptr, (IdxWidth+1)-bit modular subtraction, range 0..Depth.

Test Plan:
- Depth=4, BypassEn=0; alloc 4 (idx 0,1,2,3); rsp idx3=0xD3, 2=0xD2, 1=0xD1, 0=0xD0 on consecutive cycles, out_ready_i=1 -> out_data_o 0xD0,0xD1,0xD2,0xD3 on 4 consecutive cycles. First out_valid_o one cycle after the idx0 write. count_o 4->0.
- Full and wrap: alloc 4 -> alloc_ready_o=0, count_o=4. A 5th alloc_valid_i is not accepted. Pop 1 -> alloc_ready_o=1 and next alloc_idx_o=0. Repeat for 3 full wraps; order preserved.
- Bypass: BypassEn=1, alloc idx0; rsp idx0=0xAA with out_ready_i=1 -> out_valid_o=1, out_data_o=0xAA in the same cycle; next cycle count_o=0.
- Bypass stall: BypassEn=1, out_ready_i=0 during the bypass write -> out_valid_o stays 1 with 0xAA until out_ready_i=1. Exactly one pop.
- Errors: rsp to idx2 with nothing allocated -> err_o=1 for exactly 1 cycle, no output. Allocate idx0, write 0x11 twice -> second write raises err_o and out_data_o remains 0x11.
- Reset mid-op: 3 allocated, 2 filled, assert rst_i one cycle -> next cycle count_o=0, out_valid_o=0, alloc_idx_o=0, err_o=0. A subsequent rsp to idx1 raises err_o.

Source files
------------

// File: rtl/floo_rob_tagged.sv
// Tagged reorder buffer: slots are allocated in order, filled by tag in any order, drained in order.
// Latency: rsp write to out_valid_o is 1 cycle, or 0 cycles via head bypass; alloc_idx_o is combinational.
// Backpressure: alloc stalls when full, responses are never stalled, and the head holds until out_ready_i.
module floo_rob_tagged #(
    parameter int unsigned DataWidth = 64,
    parameter int unsigned Depth     = 64,
    parameter bit          BypassEn  = 1'b1,
    parameter int unsigned IdxWidth  = $clog2(Depth)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 alloc_valid_i,
    output logic                 alloc_ready_o,
    output logic [IdxWidth-1:0]  alloc_idx_o,
    input  logic                 rsp_valid_i,
    output logic                 rsp_ready_o,
    input  logic [IdxWidth-1:0]  rsp_idx_i,
    input  logic [DataWidth-1:0] rsp_data_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [DataWidth-1:0] out_data_o,
    output logic [IdxWidth:0]    count_o,
    output logic                 err_o
);

    localparam logic [IdxWidth:0] PtrOne = 1;

    logic [IdxWidth:0]    wr_ptr_q, wr_ptr_d;
    logic [IdxWidth:0]    rd_ptr_q, rd_ptr_d;
    logic [Depth-1:0]     alloc_q, alloc_d;
    logic [Depth-1:0]     filled_q, filled_d;
    logic [DataWidth-1:0] data_q [Depth];
    logic                 err_q, err_d;

    logic [IdxWidth-1:0]  head;
    logic [IdxWidth-1:0]  wr_idx;
    logic                 full;
    logic                 alloc_fire;
    logic                 rsp_legal;
    logic                 wr_fire;
    logic                 bypass;
    logic                 pop;

    assign head   = rd_ptr_q[IdxWidth-1:0];
    assign wr_idx = wr_ptr_q[IdxWidth-1:0];
    assign full   = (wr_ptr_q[IdxWidth] != rd_ptr_q[IdxWidth]) &&
                    (wr_idx == head);

    assign alloc_ready_o = !full;
    assign alloc_idx_o   = wr_idx;
    assign alloc_fire    = alloc_valid_i && !full;

    assign rsp_ready_o = 1'b1;
    assign rsp_legal   = alloc_q[rsp_idx_i] && !filled_q[rsp_idx_i];
    assign wr_fire     = rsp_valid_i && rsp_legal;

    // A response landing on the waiting head can be forwarded in the same cycle.
    assign bypass = BypassEn && rsp_valid_i && (rsp_idx_i == head) &&
                    alloc_q[head] && !filled_q[head];

    assign out_valid_o = filled_q[head] || bypass;
    assign out_data_o  = bypass ? rsp_data_i : data_q[head];
    assign pop         = out_valid_o && out_ready_i;

    assign count_o = wr_ptr_q - rd_ptr_q;
    assign err_o   = err_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        alloc_d  = alloc_q;
        filled_d = filled_q;
        err_d    = rsp_valid_i && !rsp_legal;

        // A bypassed response that is consumed immediately never occupies the slot.
        if (wr_fire && !(bypass && pop)) begin
            filled_d[rsp_idx_i] = 1'b1;
        end

        if (pop) begin
            alloc_d[head]  = 1'b0;
            filled_d[head] = 1'b0;
            rd_ptr_d       = rd_ptr_q + PtrOne;
        end

        if (alloc_fire) begin
            alloc_d[wr_idx]  = 1'b1;
            filled_d[wr_idx] = 1'b0;
            wr_ptr_d         = wr_ptr_q + PtrOne;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            alloc_q  <= '0;
            filled_q <= '0;
            err_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            alloc_q  <= alloc_d;
            filled_q <= filled_d;
            err_q    <= err_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_fire) begin
            data_q[rsp_idx_i] <= rsp_data_i;
        end
    end

endmodule

// File: tb/tb_floo_rob_tagged.sv
// Bench for floo_rob_tagged: directed scenarios on a no-bypass and a bypass instance,
// plus a randomized run of the bypass instance against a queue-based reference model.
module tb_floo_rob_tagged;

    localparam int DW = 8;
    localparam int D  = 4;
    localparam int IW = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // instance 0: BypassEn = 0
    logic          s0_rst, s0_av, s0_ar, s0_rv, s0_rr, s0_ov, s0_or, s0_err;
    logic [IW-1:0] s0_ai, s0_ri;
    logic [DW-1:0] s0_rd, s0_od;
    logic [IW:0]   s0_cnt;

    // instance 1: BypassEn = 1
    logic          s1_rst, s1_av, s1_ar, s1_rv, s1_rr, s1_ov, s1_or, s1_err;
    logic [IW-1:0] s1_ai, s1_ri;
    logic [DW-1:0] s1_rd, s1_od;
    logic [IW:0]   s1_cnt;

    floo_rob_tagged #(.DataWidth(DW), .Depth(D), .BypassEn(1'b0)) u_dut0 (
        .clk_i(clk), .rst_i(s0_rst),
        .alloc_valid_i(s0_av), .alloc_ready_o(s0_ar), .alloc_idx_o(s0_ai),
        .rsp_valid_i(s0_rv), .rsp_ready_o(s0_rr), .rsp_idx_i(s0_ri), .rsp_data_i(s0_rd),
        .out_valid_o(s0_ov), .out_ready_i(s0_or), .out_data_o(s0_od),
        .count_o(s0_cnt), .err_o(s0_err)
    );

    floo_rob_tagged #(.DataWidth(DW), .Depth(D), .BypassEn(1'b1)) u_dut1 (
        .clk_i(clk), .rst_i(s1_rst),
        .alloc_valid_i(s1_av), .alloc_ready_o(s1_ar), .alloc_idx_o(s1_ai),
        .rsp_valid_i(s1_rv), .rsp_ready_o(s1_rr), .rsp_idx_i(s1_ri), .rsp_data_i(s1_rd),
        .out_valid_o(s1_ov), .out_ready_i(s1_or), .out_data_o(s1_od),
        .count_o(s1_cnt), .err_o(s1_err)
    );

    task automatic reset1();
        @(negedge clk);
        s1_rst = 1'b1; s1_av = 1'b0; s1_rv = 1'b0; s1_or = 1'b0;
        @(negedge clk);
        s1_rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        s0_rst = 1'b1; s1_rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        s0_rst = 1'b0; s1_rst = 1'b0;
        #1;
        total++; if (s0_ar !== 1'b1) begin bad++; $display("FAIL rst0_ready got=%0d exp=1", s0_ar); end
        total++; if (s0_ai !== 2'd0) begin bad++; $display("FAIL rst0_idx got=%0d exp=0", s0_ai); end
        total++; if (s0_ov !== 1'b0) begin bad++; $display("FAIL rst0_valid got=%0d exp=0", s0_ov); end
        total++; if (s0_cnt !== 3'd0) begin bad++; $display("FAIL rst0_count got=%0d exp=0", s0_cnt); end
        total++; if (s0_err !== 1'b0) begin bad++; $display("FAIL rst0_err got=%0d exp=0", s0_err); end
        total++; if (s1_ar !== 1'b1 || s1_ai !== 2'd0 || s1_ov !== 1'b0 || s1_cnt !== 3'd0 || s1_err !== 1'b0) begin
            bad++; $display("FAIL rst1_outputs got=%0d/%0d/%0d/%0d/%0d exp=1/0/0/0/0", s1_ar, s1_ai, s1_ov, s1_cnt, s1_err);
        end
        total++; if (s0_rr !== 1'b1 || s1_rr !== 1'b1) begin bad++; $display("FAIL rsp_ready got=%0d/%0d exp=1/1", s0_rr, s1_rr); end
    endtask

    task automatic test_inorder();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            s0_av = 1'b1;
            #1;
            total++; if (s0_ai !== i[IW-1:0] || s0_ar !== 1'b1) begin bad++; $display("FAIL ino_alloc%0d got=%0d/%0d exp=%0d/1", i, s0_ai, s0_ar, i); end
        end
        @(negedge clk);
        s0_av = 1'b0;
        #1;
        total++; if (s0_cnt !== 3'd4) begin bad++; $display("FAIL ino_full_cnt got=%0d exp=4", s0_cnt); end
        total++; if (s0_ar !== 1'b0) begin bad++; $display("FAIL ino_full_rdy got=%0d exp=0", s0_ar); end
        @(negedge clk);
        s0_av = 1'b1;
        @(negedge clk);
        s0_av = 1'b0;
        #1;
        total++; if (s0_cnt !== 3'd4 || s0_ai !== 2'd0) begin bad++; $display("FAIL ino_fifth got=%0d/%0d exp=4/0", s0_cnt, s0_ai); end
        s0_or = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            s0_rv = 1'b1; s0_ri = 2'(3 - k); s0_rd = 8'hD0 + 8'(3 - k);
            #1;
            total++; if (s0_ov !== 1'b0) begin bad++; $display("FAIL ino_novalid%0d got=%0d exp=0", k, s0_ov); end
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            s0_rv = 1'b0;
            #1;
            total++; if (s0_ov !== 1'b1 || s0_od !== 8'hD0 + 8'(k)) begin bad++; $display("FAIL ino_out%0d got=%0d/%0h exp=1/%0h", k, s0_ov, s0_od, 8'hD0 + 8'(k)); end
            total++; if (s0_cnt !== 3'(4 - k)) begin bad++; $display("FAIL ino_cnt%0d got=%0d exp=%0d", k, s0_cnt, 4 - k); end
        end
        @(negedge clk);
        s0_or = 1'b0;
        #1;
        total++; if (s0_cnt !== 3'd0 || s0_ov !== 1'b0) begin bad++; $display("FAIL ino_empty got=%0d/%0d exp=0/0", s0_cnt, s0_ov); end
    endtask

    task automatic test_wrap();
        logic [DW-1:0] exp_d [D];
        for (int w = 0; w < 3; w++) begin
            for (int j = 0; j < 4; j++) begin
                @(negedge clk);
                s0_av = 1'b1;
                #1;
                total++; if (s0_ai !== j[IW-1:0]) begin bad++; $display("FAIL wrap%0d_idx%0d got=%0d exp=%0d", w, j, s0_ai, j); end
            end
            for (int j = 0; j < 4; j++) begin
                int idx;
                idx = (j + w + 1) % 4;
                @(negedge clk);
                s0_av = 1'b0;
                s0_rv = 1'b1; s0_ri = 2'(idx); s0_rd = 8'($urandom);
                exp_d[idx] = s0_rd;
            end
            @(negedge clk);
            s0_rv = 1'b0;
            #1;
            total++; if (s0_ar !== 1'b0 || s0_cnt !== 3'd4) begin bad++; $display("FAIL wrap%0d_full got=%0d/%0d exp=0/4", w, s0_ar, s0_cnt); end
            for (int j = 0; j < 4; j++) begin
                @(negedge clk);
                s0_or = 1'b1;
                #1;
                total++; if (s0_ov !== 1'b1 || s0_od !== exp_d[j]) begin bad++; $display("FAIL wrap%0d_pop%0d got=%0d/%0h exp=1/%0h", w, j, s0_ov, s0_od, exp_d[j]); end
                if (j == 0) begin
                    total++; if (s0_ar !== 1'b0) begin bad++; $display("FAIL wrap%0d_rdy_during_pop got=%0d exp=0", w, s0_ar); end
                end
                if (j == 1) begin
                    total++; if (s0_ar !== 1'b1 || s0_ai !== 2'd0) begin bad++; $display("FAIL wrap%0d_after_pop got=%0d/%0d exp=1/0", w, s0_ar, s0_ai); end
                end
            end
            @(negedge clk);
            s0_or = 1'b0;
            #1;
            total++; if (s0_cnt !== 3'd0) begin bad++; $display("FAIL wrap%0d_empty got=%0d exp=0", w, s0_cnt); end
        end
    endtask

    task automatic test_bypass();
        @(negedge clk);
        s1_av = 1'b1;
        #1;
        total++; if (s1_ai !== 2'd0) begin bad++; $display("FAIL byp_idx got=%0d exp=0", s1_ai); end
        @(negedge clk);
        s1_av = 1'b0; s1_rv = 1'b1; s1_ri = 2'd0; s1_rd = 8'hAA; s1_or = 1'b1;
        #1;
        total++; if (s1_ov !== 1'b1 || s1_od !== 8'hAA) begin bad++; $display("FAIL byp_same_cycle got=%0d/%0h exp=1/aa", s1_ov, s1_od); end
        @(negedge clk);
        s1_rv = 1'b0; s1_or = 1'b0;
        #1;
        total++; if (s1_cnt !== 3'd0 || s1_ov !== 1'b0) begin bad++; $display("FAIL byp_after got=%0d/%0d exp=0/0", s1_cnt, s1_ov); end
    endtask

    task automatic test_bypass_stall();
        @(negedge clk);
        s1_av = 1'b1;
        #1;
        total++; if (s1_ai !== 2'd1) begin bad++; $display("FAIL stall_idx got=%0d exp=1", s1_ai); end
        @(negedge clk);
        s1_av = 1'b0; s1_rv = 1'b1; s1_ri = 2'd1; s1_rd = 8'hAA; s1_or = 1'b0;
        #1;
        total++; if (s1_ov !== 1'b1 || s1_od !== 8'hAA) begin bad++; $display("FAIL stall_first got=%0d/%0h exp=1/aa", s1_ov, s1_od); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            s1_rv = 1'b0; s1_rd = 8'h55;
            #1;
            total++; if (s1_ov !== 1'b1 || s1_od !== 8'hAA || s1_cnt !== 3'd1) begin bad++; $display("FAIL stall_hold%0d got=%0d/%0h/%0d exp=1/aa/1", i, s1_ov, s1_od, s1_cnt); end
        end
        @(negedge clk);
        s1_or = 1'b1;
        #1;
        total++; if (s1_ov !== 1'b1 || s1_od !== 8'hAA) begin bad++; $display("FAIL stall_accept got=%0d/%0h exp=1/aa", s1_ov, s1_od); end
        @(negedge clk);
        s1_or = 1'b0;
        #1;
        total++; if (s1_cnt !== 3'd0 || s1_ov !== 1'b0 || s1_ai !== 2'd2) begin bad++; $display("FAIL stall_onepop got=%0d/%0d/%0d exp=0/0/2", s1_cnt, s1_ov, s1_ai); end
    endtask

    task automatic test_errors();
        reset1();
        @(negedge clk);
        s1_rv = 1'b1; s1_ri = 2'd2; s1_rd = 8'h77;
        #1;
        total++; if (s1_ov !== 1'b0 || s1_err !== 1'b0) begin bad++; $display("FAIL err_unalloc_now got=%0d/%0d exp=0/0", s1_ov, s1_err); end
        @(negedge clk);
        s1_rv = 1'b0;
        #1;
        total++; if (s1_err !== 1'b1 || s1_ov !== 1'b0 || s1_cnt !== 3'd0) begin bad++; $display("FAIL err_unalloc_pulse got=%0d/%0d/%0d exp=1/0/0", s1_err, s1_ov, s1_cnt); end
        @(negedge clk);
        #1;
        total++; if (s1_err !== 1'b0) begin bad++; $display("FAIL err_unalloc_clear got=%0d exp=0", s1_err); end
        @(negedge clk);
        s1_av = 1'b1;
        @(negedge clk);
        s1_av = 1'b0; s1_rv = 1'b1; s1_ri = 2'd0; s1_rd = 8'h11; s1_or = 1'b0;
        @(negedge clk);
        s1_rd = 8'h22;
        #1;
        total++; if (s1_err !== 1'b0 || s1_od !== 8'h11) begin bad++; $display("FAIL err_first_fill got=%0d/%0h exp=0/11", s1_err, s1_od); end
        @(negedge clk);
        s1_rv = 1'b0;
        #1;
        total++; if (s1_err !== 1'b1 || s1_ov !== 1'b1 || s1_od !== 8'h11) begin bad++; $display("FAIL err_double got=%0d/%0d/%0h exp=1/1/11", s1_err, s1_ov, s1_od); end
        @(negedge clk);
        #1;
        total++; if (s1_err !== 1'b0) begin bad++; $display("FAIL err_double_clear got=%0d exp=0", s1_err); end
        @(negedge clk);
        s1_or = 1'b1;
        @(negedge clk);
        s1_or = 1'b0;
        s1_rv = 1'b1; s1_ri = 2'd3;
        @(negedge clk);
        #1;
        total++; if (s1_err !== 1'b1) begin bad++; $display("FAIL err_b2b_first got=%0d exp=1", s1_err); end
        @(negedge clk);
        s1_rv = 1'b0;
        #1;
        total++; if (s1_err !== 1'b1) begin bad++; $display("FAIL err_b2b_second got=%0d exp=1", s1_err); end
        @(negedge clk);
        #1;
        total++; if (s1_err !== 1'b0 || s1_cnt !== 3'd0) begin bad++; $display("FAIL err_b2b_end got=%0d/%0d exp=0/0", s1_err, s1_cnt); end
    endtask

    task automatic test_reset_midop();
        reset1();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            s1_av = 1'b1;
        end
        @(negedge clk);
        s1_av = 1'b0; s1_rv = 1'b1; s1_ri = 2'd0; s1_rd = 8'h01; s1_or = 1'b0;
        @(negedge clk);
        s1_ri = 2'd1; s1_rd = 8'h02;
        @(negedge clk);
        s1_ri = 2'd3;
        @(negedge clk);
        s1_rv = 1'b0; s1_rst = 1'b1;
        @(negedge clk);
        s1_rst = 1'b0;
        #1;
        total++; if (s1_cnt !== 3'd0 || s1_ov !== 1'b0 || s1_ai !== 2'd0 || s1_err !== 1'b0 || s1_ar !== 1'b1) begin
            bad++; $display("FAIL midrst_state got=%0d/%0d/%0d/%0d/%0d exp=0/0/0/0/1", s1_cnt, s1_ov, s1_ai, s1_err, s1_ar);
        end
        @(negedge clk);
        s1_rv = 1'b1; s1_ri = 2'd1;
        #1;
        total++; if (s1_ov !== 1'b0) begin bad++; $display("FAIL midrst_nobyp got=%0d exp=0", s1_ov); end
        @(negedge clk);
        s1_rv = 1'b0;
        #1;
        total++; if (s1_err !== 1'b1 || s1_ov !== 1'b0) begin bad++; $display("FAIL midrst_err got=%0d/%0d exp=1/0", s1_err, s1_ov); end
    endtask

    // Reference: an ordered list of outstanding slots plus per-slot fill state.
    task automatic test_random();
        int            q[$];
        bit            mf [D];
        logic [DW-1:0] md [D];
        int            nalloc;
        bit            prev_ill;
        reset1();
        nalloc = 0; prev_ill = 1'b0;
        for (int i = 0; i < D; i++) begin mf[i] = 1'b0; md[i] = '0; end
        for (int c = 0; c < 600; c++) begin
            bit            legal, byp, e_ov, inq, pop;
            logic [DW-1:0] e_od;
            @(negedge clk);
            s1_av = ($urandom_range(0, 9) < 6);
            s1_rv = ($urandom_range(0, 1) == 1);
            if (q.size() > 0 && $urandom_range(0, 3) != 0) s1_ri = 2'(q[$urandom_range(0, q.size() - 1)]);
            else s1_ri = 2'($urandom_range(0, 3));
            s1_rd = 8'($urandom);
            s1_or = ($urandom_range(0, 9) < 6);
            #1;
            inq = 1'b0;
            foreach (q[k]) if (q[k] == int'(s1_ri)) inq = 1'b1;
            legal = s1_rv && inq && !mf[s1_ri];
            byp   = s1_rv && q.size() > 0 && q[0] == int'(s1_ri) && !mf[s1_ri];
            e_ov  = (q.size() > 0 && mf[q[0]]) || byp;
            e_od  = (q.size() > 0 && mf[q[0]]) ? md[q[0]] : s1_rd;
            total++; if (s1_ar !== (q.size() < D)) begin bad++; $display("FAIL rnd%0d_ready got=%0d exp=%0d", c, s1_ar, q.size() < D); end
            total++; if (s1_ai !== 2'(nalloc % D)) begin bad++; $display("FAIL rnd%0d_idx got=%0d exp=%0d", c, s1_ai, nalloc % D); end
            total++; if (s1_cnt !== 3'(q.size())) begin bad++; $display("FAIL rnd%0d_count got=%0d exp=%0d", c, s1_cnt, q.size()); end
            total++; if (s1_err !== prev_ill) begin bad++; $display("FAIL rnd%0d_err got=%0d exp=%0d", c, s1_err, prev_ill); end
            total++; if (s1_ov !== e_ov) begin bad++; $display("FAIL rnd%0d_valid got=%0d exp=%0d", c, s1_ov, e_ov); end
            if (e_ov) begin
                total++; if (s1_od !== e_od) begin bad++; $display("FAIL rnd%0d_data got=%0h exp=%0h", c, s1_od, e_od); end
            end
            pop = e_ov && s1_or;
            if (legal && !(byp && pop)) begin mf[s1_ri] = 1'b1; md[s1_ri] = s1_rd; end
            if (pop) begin mf[q[0]] = 1'b0; void'(q.pop_front()); end
            if (s1_av && q.size() < D + (pop ? 1 : 0) && (q.size() + (pop ? 1 : 0)) <= D) begin
                // ready was sampled before the pop, so judge it on the pre-pop occupancy
            end
            if (s1_av && (q.size() + (pop ? 1 : 0)) < D) begin
                q.push_back(nalloc % D); mf[nalloc % D] = 1'b0; nalloc++;
            end
            prev_ill = s1_rv && !legal;
        end
        @(negedge clk);
        s1_av = 1'b0; s1_rv = 1'b0; s1_or = 1'b0;
    endtask

    initial begin
        s0_rst = 1'b1; s0_av = 1'b0; s0_rv = 1'b0; s0_ri = '0; s0_rd = '0; s0_or = 1'b0;
        s1_rst = 1'b1; s1_av = 1'b0; s1_rv = 1'b0; s1_ri = '0; s1_rd = '0; s1_or = 1'b0;
        test_reset();
        test_inorder();
        test_wrap();
        test_bypass();
        test_bypass_stall();
        test_errors();
        test_reset_midop();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
